// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and parity helper for the oversampled UART receiver.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_START     = 3'd1;
  localparam state_t ST_DATA      = 3'd2;
  localparam state_t ST_PARITY    = 3'd3;
  localparam state_t ST_STOP      = 3'd4;
  localparam state_t ST_WAIT_HIGH = 3'd5;

  function automatic logic expected_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; a push while full is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk2) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk2) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x oversampled UART receiver with optional parity, error pulses and a small receive FIFO.
//   state     | meaning
//   IDLE      | line idle, waiting for a low level
//   START     | confirming start bit at mid-bit
//   DATA      | shifting in 8 data bits, LSB first
//   PARITY    | sampling the parity bit
//   STOP      | sampling the stop bit, push or report error
//   WAIT_HIGH | after a framing error, wait for the line to return high
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       doner,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  state_t               state;
  logic [3:0]           sample_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_flag;
  logic                 mid_bit;
  logic                 stop_mid;
  logic                 push_req;

  always_ff @(posedge clk2) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst || tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end

  assign tick     = (div_cnt == DIV_LAST);
  assign mid_bit  = tick && (sample_cnt == LAST_SAMPLE);
  assign stop_mid = (state == ST_STOP) && mid_bit;
  assign push_req = stop_mid && rx_s && !par_flag;

  always_ff @(posedge clk2) begin
    if (rst) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      par_flag   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state      <= ST_START;
            sample_cnt <= '0;
            bit_idx    <= '0;
            par_flag   <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (sample_cnt == MID_SAMPLE) begin
              sample_cnt <= '0;
              state      <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        // From here the counter wraps 15->0, so each sample lands 16 ticks after the last.
        ST_DATA: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == LAST_SAMPLE) begin
              shift   <= {rx_s, shift[DATA_BITS-1:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == LAST_BIT) state <= PARITY_EN ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == LAST_SAMPLE) begin
              if (rx_s != expected_parity(shift, PARITY_ODD)) par_flag <= 1'b1;
              state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == LAST_SAMPLE) state <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pulses are registered so doner lines up with the FIFO already showing the new byte.
  always_ff @(posedge clk2) begin
    if (rst) begin
      doner      <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      doner      <= push_req && (!full || rd_en);
      overrun    <= push_req && full && !rd_en;
      parity_err <= stop_mid && rx_s && par_flag;
      frame_err  <= stop_mid && !rx_s;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk2    (clk2),
    .rst     (rst),
    .push    (push_req),
    .pop     (rd_en),
    .wr_data (shift),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full)
  );

endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 Parameter CLK_DIV, default 27, meaning clk2 cycles per oversample tick (16 ticks per bit).
REQ-002 Parameter PARITY_EN, default 1, meaning a parity bit follows the data bits.
REQ-003 Parameter PARITY_ODD, default 0, meaning odd parity when 1 and even parity when 0.
REQ-004 Parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of 2).
REQ-005 Port clk2  input  1  sole clock.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port rx  input  1  asynchronous serial line, idle high.
REQ-008 Port rd_en  input  1  pops the FIFO head.
REQ-009 Port rd_data  output  8  FIFO head (show-ahead).
REQ-010 Port empty  output  1  FIFO holds 0 entries.
REQ-011 Port full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 Port doner  output  1  one-cycle pulse when a byte is written to the FIFO.
REQ-013 Port parity_err  output  1  one-cycle pulse on a parity mismatch.
REQ-014 Port frame_err  output  1  one-cycle pulse when the stop bit is 0.
REQ-015 Port overrun  output  1  one-cycle pulse when a valid byte is dropped because the FIFO is full.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value.
REQ-017 Tick counter: counts 0..CLK_DIV-1 and SHALL assert tick for one cycle at CLK_DIV-1, free-running.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; the 4-bit sample counter advances on tick.
REQ-019 IDLE -> START on synced rx=0; the sample counter clears.
REQ-020 START: at sample 7 (mid-bit), rx=0 -> DATA with counter cleared; rx=1 -> IDLE (glitch rejection, no error).
REQ-021 DATA: sample every 16 ticks at mid-bit, 8 bits LSB first; then PARITY if PARITY_EN, else STOP.
REQ-022 PARITY: the mid-bit sample SHALL be compared with XOR(data) XOR PARITY_ODD; a mismatch sets an internal flag.
REQ-023 STOP, mid-bit rx=1, parity flag clear: push the byte, pulse doner the next cycle, go to IDLE.
REQ-024 STOP, mid-bit rx=1, parity flag set: discard the byte, pulse parity_err, go to IDLE.
REQ-025 STOP, mid-bit rx=0: discard the byte, pulse frame_err (parity_err suppressed), go to WAIT_HIGH.
REQ-026 WAIT_HIGH -> IDLE on synced rx=1 (no false start on a break).
REQ-027 Push while full with no rd_en: byte dropped, overrun pulses, FIFO unchanged, doner stays 0.
REQ-028 Push and rd_en in the same cycle while full: both occur, no overrun, count unchanged.
REQ-029 rd_en while empty SHALL be ignored; rd_data SHALL be 8'h00 while empty.
REQ-030 empty deasserts and rd_data is valid in the same cycle doner pulses.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-032 On rst: FSM=IDLE, all counters=0, synchronizer flops=1, FIFO empty.
REQ-033 Reset outputs: rd_data=0, empty=1, full=0, doner=parity_err=frame_err=overrun=0.
REQ-034 rst mid-frame SHALL abandon the frame without pulsing any error.

Structure
REQ-035 Package uart_pkg SHALL hold the FSM state typedef, DATA_BITS=8, OVERSAMPLE=16 and MID_SAMPLE=7.
REQ-036 The FIFO SHALL be a sub-module uart_rx_fifo (push, pop, data, empty, full); everything else stays in the top.

Verification (CLK_DIV=4, PARITY_EN=1, even parity unless stated)
REQ-037 Frame 0xA5, parity 0, stop 1 -> doner pulse, rd_data=0xA5, empty=0; rd_en -> empty=1.
REQ-038 rx low for 5 ticks then high -> no doner, no error pulses, FSM back in IDLE.
REQ-039 Frame 0x3C with stop bit 0, line held low 2 bit-times -> frame_err once, FIFO empty; the following 0x11 frame is received correctly.
REQ-040 Frame 0x01 with parity bit 0 -> parity_err pulse, no doner, FIFO empty.
REQ-041 Bytes 0x10..0x14 sent with no reads -> full after 4, overrun on the 5th; reads return 0x10, 0x11, 0x12, 0x13 in order.
REQ-042 rst asserted during DATA bit 4 -> all outputs at reset values; the next 0x5A frame is received correctly.
